palette_color_mapper: RTL and testbench

Registered, palette-based successor to the fixed-colour mapper. It sits between the sprite/tile renderers and the VGA DAC outputs. It takes a palette index per layer, resolves layer priority, and looks up a writable RGB palette. It applies a frame-synchronous blink substitution (for example, frightened-ghost flashing) and blanking. All outputs are registered with a fixed 2-cycle latency.

---
 rtl/palette_color_mapper.sv | 138 +++++++++++++
 tb/tb_palette_color_mapper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/palette_color_mapper.sv
// Palette colour mapper: layer priority, writable RGB palette, blink, blank.
// Optional debug grid overlay: define COLOR_MAPPER_GRID_EN.
module palette_color_mapper #(
  parameter int              LAYERS        = 3,
  parameter int              IDX_W         = 4,
  parameter int              COLOR_W       = 8,
  parameter logic [23:0]     BG_COLOR      = 24'hFF5500,
  parameter logic [IDX_W-1:0] BLINK_IDX    = 4'hE,
  parameter logic [IDX_W-1:0] BLINK_ALT_IDX = 4'hF,
  parameter int              BLINK_FRAMES  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    blank,
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  logic [LAYERS*IDX_W-1:0] layer_idx,
  input  logic                    pal_we,
  input  logic [IDX_W-1:0]        pal_waddr,
  input  logic [3*COLOR_W-1:0]    pal_wdata,
  output logic [COLOR_W-1:0]      red,
  output logic [COLOR_W-1:0]      green,
  output logic [COLOR_W-1:0]      blue,
  output logic                    blink_phase
);

  localparam int DEPTH = 2**IDX_W;
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;
  localparam logic [7:0] BG_R8 = BG_COLOR[23:16];
  localparam logic [7:0] BG_G8 = BG_COLOR[15:8];
  localparam logic [7:0] BG_B8 = BG_COLOR[7:0];
  localparam logic [COLOR_W-1:0] BG_R = COLOR_W'(BG_R8);
  localparam logic [COLOR_W-1:0] BG_G = COLOR_W'(BG_G8);
  localparam logic [COLOR_W-1:0] BG_B = COLOR_W'(BG_B8);
  localparam logic [3*COLOR_W-1:0] BG = {BG_R, BG_G, BG_B};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [3*COLOR_W-1:0] pal [DEPTH];
  logic [IDX_W-1:0]     sel;
  logic [CNT_W-1:0]     cnt;
  logic [3*COLOR_W-1:0] s1_color;
  logic                 s1_blank;

  // Palette storage; reads in the write cycle still see the old entry
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        pal[i] <= (i == 0) ? BG : '0;
    end else if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

  // Highest nonzero layer wins, then blink substitution
  always_comb begin
    sel = '0;
    for (int i = 0; i < LAYERS; i++)
      if (layer_idx[i*IDX_W +: IDX_W] != '0)
        sel = layer_idx[i*IDX_W +: IDX_W];
    if (blink_phase && sel == BLINK_IDX)
      sel = BLINK_ALT_IDX;
  end

  // Frame counter toggling the blink phase every BLINK_FRAMES frames
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (cnt == CNT_LAST) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: latch looked-up colour and blank
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_color <= '0;
      s1_blank <= 1'b0;
    end else begin
      s1_color <= pal[sel];
      s1_blank <= blank;
    end
  end

`ifdef COLOR_MAPPER_GRID_EN
  localparam logic [COLOR_W-1:0] GRID_C = {COLOR_W{1'b1}} >> 1;

  logic [9:0] s1_x;
  logic [9:0] s1_y;
  logic       on_grid;

  // Stage 1 coordinates for the grid overlay
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_x <= '0;
      s1_y <= '0;
    end else begin
      s1_x <= draw_x;
      s1_y <= draw_y;
    end
  end

  assign on_grid = (s1_x[3:0] == 4'd0) || (s1_y[3:0] == 4'd0);

  // Stage 2: blanking over grid over palette colour
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {red, green, blue} <= '0;
    end else if (!s1_blank) begin
      {red, green, blue} <= '0;
    end else if (on_grid) begin
      {red, green, blue} <= {GRID_C, GRID_C, GRID_C};
    end else begin
      {red, green, blue} <= s1_color;
    end
  end
`else
  wire unused_coords = ^{draw_x, draw_y};

  // Stage 2: blanking over palette colour
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      {red, green, blue} <= '0;
    end else if (!s1_blank) begin
      {red, green, blue} <= '0;
    end else begin
      {red, green, blue} <= s1_color;
    end
  end
`endif

endmodule

// File: tb/tb_palette_color_mapper.sv
// Scoreboard bench for palette_color_mapper.
// Reference model works from frame counts and a palette array.
module tb_palette_color_mapper;
  localparam int L  = 3;
  localparam int IW = 4;
  localparam int CW = 8;
  localparam int BF = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          blank = 1'b0;
  logic [9:0]    draw_x = '0;
  logic [9:0]    draw_y = '0;
  logic [L*IW-1:0] layer_idx = '0;
  logic          pal_we = 1'b0;
  logic [IW-1:0] pal_waddr = '0;
  logic [3*CW-1:0] pal_wdata = '0;
  logic [CW-1:0] red, green, blue;
  logic          blink_phase;

  palette_color_mapper #(
    .LAYERS(L), .IDX_W(IW), .COLOR_W(CW),
    .BG_COLOR(24'hFF5500), .BLINK_IDX(4'hE),
    .BLINK_ALT_IDX(4'hF), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .frame_start(frame_start), .blank(blank),
    .draw_x(draw_x), .draw_y(draw_y),
    .layer_idx(layer_idx),
    .pal_we(pal_we), .pal_waddr(pal_waddr),
    .pal_wdata(pal_wdata),
    .red(red), .green(green), .blue(blue),
    .blink_phase(blink_phase)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [23:0] mpal [16];
  int          frames;

  function automatic logic mphase();
    return ((frames / BF) % 2) == 1;
  endfunction

  function automatic logic [23:0] model(
    input logic [L*IW-1:0] li,
    input logic bl,
    input logic [9:0] x,
    input logic [9:0] y
  );
    int s;
    logic found;
    s = 0;
    found = 1'b0;
    for (int i = L - 1; i >= 0; i--)
      if (!found && li[i*IW +: IW] != 0) begin
        s = int'(li[i*IW +: IW]);
        found = 1'b1;
      end
    if (mphase() && s == 14) s = 15;
    if (!bl) return 24'h0;
`ifdef COLOR_MAPPER_GRID_EN
    if (x[3:0] == 4'd0 || y[3:0] == 4'd0) return 24'h7F7F7F;
`else
    if (x == 10'h3FF && y == 10'h3FF) return mpal[s];
`endif
    return mpal[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mpal[i] = 24'h0;
    mpal[0] = 24'hFF5500;
    frames = 0;
  endtask

  // drive one pixel, record its expectation, advance the model
  task automatic step(
    input logic fs, input logic bl,
    input logic [9:0] x, input logic [9:0] y,
    input logic [L*IW-1:0] li,
    input logic we, input logic [IW-1:0] wa,
    input logic [23:0] wd
  );
    exp_t e;
    frame_start = fs;
    blank = bl;
    draw_x = x;
    draw_y = y;
    layer_idx = li;
    pal_we = we;
    pal_waddr = wa;
    pal_wdata = wd;
    e.rgb = model(li, bl, x, y);
    e.due = cyc + 2;
    q.push_back(e);
    if (we) mpal[wa] = wd;
    if (fs) frames++;
    @(negedge Clk);
  endtask

  task automatic px(input logic [L*IW-1:0] li, input logic bl);
    step(1'b0, bl, 10'd1, 10'd1, li, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [23:0] d);
    step(1'b0, 1'b1, 10'd1, 10'd1, '0, 1'b1, a, d);
  endtask

  // monitor: blink phase every cycle, RGB when a pixel is due
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (!Reset) begin
      vectors++;
      if (blink_phase !== mphase()) begin
        errors++;
        $display("FAIL blink_phase cyc=%0d got %b want %b",
                 cyc, blink_phase, mphase());
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        vectors++;
        if (e.due != cyc) begin
          errors++;
          $display("FAIL latency due=%0d cyc=%0d", e.due, cyc);
        end else if ({red, green, blue} !== e.rgb) begin
          errors++;
          $display("FAIL rgb cyc=%0d got %h want %h",
                   cyc, {red, green, blue}, e.rgb);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    repeat (4) px(12'h000, 1'b1);

    wr(4'd3, 24'h0000FF);
    wr(4'd5, 24'hFFFF00);
    px(12'h503, 1'b1);
    px(12'h003, 1'b1);
    px(12'h030, 1'b1);

    step(1'b0, 1'b1, 10'd1, 10'd1, 12'h007,
         1'b1, 4'd7, 24'h123456);
    px(12'h007, 1'b1);

    wr(4'hE, 24'h0000FF);
    wr(4'hF, 24'hFFFFFF);
    for (int i = 0; i < 10; i++)
      step(i % 2 == 0, 1'b1, 10'd1, 10'd1, 12'h00E,
           1'b0, '0, '0);
    px(12'h00E, 1'b1);
    px(12'hE00, 1'b1);

    for (int i = 0; i < 8; i++)
      px(12'h305, i % 2 == 1);
    px(12'h305, 1'b0);

    step(1'b0, 1'b1, 10'd16, 10'd5, 12'h003, 1'b0, '0, '0);
    step(1'b0, 1'b1, 10'd17, 10'd1, 12'h003, 1'b0, '0, '0);
    step(1'b0, 1'b1, 10'd17, 10'd32, 12'h005, 1'b0, '0, '0);

    repeat (3) px(12'h000, 1'b1);
    Reset = 1'b1;
    #1;
    vectors++;
    if ({red, green, blue, blink_phase} !== 25'h0) begin
      errors++;
      $display("FAIL async_reset got %h/%b want 0/0",
               {red, green, blue}, blink_phase);
    end
    q.delete();
    model_reset();
    frame_start = 1'b0;
    pal_we = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [L*IW-1:0] li;
      li = L*IW'($urandom);
      for (int k = 0; k < L; k++)
        if ($urandom_range(2) == 0) li[k*IW +: IW] = '0;
      step($urandom_range(5) == 0,
           $urandom_range(7) != 0,
           10'($urandom), 10'($urandom), li,
           $urandom_range(3) == 0,
           4'($urandom), 24'($urandom));
    end

    frame_start = 1'b0;
    pal_we = 1'b0;
    repeat (4) @(negedge Clk);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
